dijkstra_path_extractor: RTL and testbench

//  Downstream of DijkstraTop. Once DijkstraTop raises ready, this block walks the prev[] array
//  it left in BlockRam, from destination back to source, and streams the path out in forward

---
 rtl/dijkstra_path_extractor.sv | 226 ++++++++++++++++++++++
 tb/tb_dijkstra_path_extractor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_path_extractor.sv
// Walks the prev[] array left in BlockRam from destination back to source and
// streams the path out source-first on a valid/ready port.
module dijkstra_path_extractor #(
    parameter int unsigned MADDR_WIDTH = 32,
    parameter int unsigned MDATA_WIDTH = 32,
    parameter int unsigned MAX_NODES   = 16,
    parameter int unsigned INDEX_WIDTH = 8,
    parameter logic [INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] destination,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [MADDR_WIDTH-1:0] base_address,
    output logic                   mem_read_enable,
    input  logic                   mem_read_ready,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    output logic [INDEX_WIDTH-1:0] path_node,
    output logic                   path_valid,
    output logic                   path_last,
    input  logic                   path_ready,
    output logic [INDEX_WIDTH:0]   path_length,
    output logic                   error,
    output logic                   ready
);

    localparam int unsigned CW     = INDEX_WIDTH + 1;
    localparam int unsigned SW     = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam int unsigned STRIDE = MADDR_WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_EMIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] src_q, src_d;
    logic [INDEX_WIDTH-1:0] n_q, n_d;
    logic [MADDR_WIDTH-1:0] base_q, base_d;
    logic [INDEX_WIDTH-1:0] nxt_q, nxt_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          len_q, len_d;
    logic                   rd_q, rd_d;
    logic [MADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INDEX_WIDTH-1:0] node_q, node_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;

    logic [INDEX_WIDTH-1:0] stack_q [MAX_NODES];
    logic                   push_c;
    logic [SW-1:0]          push_idx_c;
    logic [INDEX_WIDTH-1:0] push_val_c;
    logic [CW-1:0]          count_inc_c;
    logic                   unused_data_c;

    assign unused_data_c = ^mem_read_data[MDATA_WIDTH-1:INDEX_WIDTH];
    assign count_inc_c   = count_q + CW'(1);

    function automatic logic [MADDR_WIDTH-1:0] prev_addr(input logic [MADDR_WIDTH-1:0] b,
                                                         input logic [INDEX_WIDTH-1:0] n,
                                                         input logic [INDEX_WIDTH-1:0] j);
        return b + (MADDR_WIDTH'(n) * MADDR_WIDTH'(n) + MADDR_WIDTH'(j)) * MADDR_WIDTH'(STRIDE);
    endfunction

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        n_d        = n_q;
        base_d     = base_q;
        nxt_d      = nxt_q;
        count_d    = count_q;
        len_d      = len_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        node_d     = node_q;
        valid_d    = valid_q;
        last_d     = last_q;
        ready_d    = ready_q;
        err_d      = err_q;
        push_c     = 1'b0;
        push_idx_c = '0;
        push_val_c = '0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    src_d   = source;
                    n_d     = number_of_nodes;
                    base_d  = base_address;
                    len_d   = '0;
                    count_d = '0;
                    if (source >= number_of_nodes || destination >= number_of_nodes) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        push_c     = 1'b1;
                        push_val_c = destination;
                        count_d    = CW'(1);
                        if (source == destination) begin
                            state_d = S_EMIT;
                            node_d  = destination;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                            len_d   = CW'(1);
                        end else begin
                            state_d = S_READ;
                            rd_d    = 1'b1;
                            addr_d  = prev_addr(base_address, number_of_nodes, destination);
                        end
                    end
                end
            end
            S_READ: begin
                if (mem_read_ready) begin
                    nxt_d   = mem_read_data[INDEX_WIDTH-1:0];
                    rd_d    = 1'b0;
                    state_d = S_CHECK;
                end
            end
            // A path of N nodes needs N-1 reads; a non-source node that would fill
            // the N-th slot can only mean a cycle in prev[].
            S_CHECK: begin
                if (nxt_q == NO_PREVIOUS_NODE || nxt_q >= n_q ||
                    count_q >= CW'(MAX_NODES) ||
                    (nxt_q != src_q && count_inc_c >= CW'(n_q))) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    push_c     = 1'b1;
                    push_idx_c = SW'(count_q);
                    push_val_c = nxt_q;
                    count_d    = count_inc_c;
                    if (nxt_q == src_q) begin
                        state_d = S_EMIT;
                        len_d   = count_inc_c;
                        node_d  = nxt_q;
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = S_READ;
                        rd_d    = 1'b1;
                        addr_d  = prev_addr(base_q, n_q, nxt_q);
                    end
                end
            end
            S_EMIT: begin
                if (valid_q && path_ready) begin
                    if (count_q == CW'(1)) begin
                        count_d = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_DONE;
                        ready_d = 1'b1;
                    end else begin
                        count_d = count_q - CW'(1);
                        node_d  = stack_q[SW'(count_q - CW'(2))];
                        last_d  = (count_q == CW'(2));
                    end
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            n_q     <= '0;
            base_q  <= '0;
            nxt_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            node_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            n_q     <= n_d;
            base_q  <= base_d;
            nxt_q   <= nxt_d;
            count_q <= count_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            node_q  <= node_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Node stack; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clock) begin
        if (push_c) begin
            stack_q[push_idx_c] <= push_val_c;
        end
    end

    assign mem_read_enable = rd_q ? 1'b1 : 1'bz;
    assign mem_addr        = rd_q ? addr_q : {MADDR_WIDTH{1'bz}};
    assign path_node       = node_q;
    assign path_valid      = valid_q;
    assign path_last       = last_q;
    assign path_length     = len_q;
    assign error           = err_q;
    assign ready           = ready_q;

endmodule

// File: tb/tb_dijkstra_path_extractor.sv
// Directed scoreboard bench for dijkstra_path_extractor: a BlockRam responder,
// a backpressure driver and a beat monitor checking against a queue of expected beats.
module tb_dijkstra_path_extractor;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 8;
    localparam logic [AW-1:0] BASE = 32'd16777176;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, enable;
    logic [IW-1:0] source, destination, number_of_nodes;
    logic [AW-1:0] base_address;
    wire           mem_read_enable;
    wire  [AW-1:0] mem_addr;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    wire  [IW-1:0] path_node;
    wire           path_valid, path_last;
    logic          path_ready;
    wire  [IW:0]   path_length;
    wire           error, ready;

    dijkstra_path_extractor #(
        .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .MAX_NODES(16), .INDEX_WIDTH(IW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .source(source), .destination(destination), .number_of_nodes(number_of_nodes),
        .base_address(base_address),
        .mem_read_enable(mem_read_enable), .mem_read_ready(mem_read_ready),
        .mem_addr(mem_addr), .mem_read_data(mem_read_data),
        .path_node(path_node), .path_valid(path_valid), .path_last(path_last),
        .path_ready(path_ready), .path_length(path_length),
        .error(error), .ready(ready)
    );

    typedef struct packed {
        logic [IW-1:0] node;
        logic          last;
    } beat_t;

    int            checks = 0;
    int            errors = 0;
    beat_t         exp_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            mem_wait = 0;
    int            reads = 0;
    logic [AW-1:0] first_addr = '0;
    bit            bp_en = 1'b0;
    int            bp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // prev[j] for base 16777176, N=8: 16777176 + (64 + j) * 4
    task automatic set_prev(input int j, input logic [DW-1:0] v);
        mem[32'd16777432 + 32'(4 * j)] = v;
    endtask

    task automatic push_beat(input logic [IW-1:0] n, input logic l);
        beat_t b;
        b.node = n;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // BlockRam responder: answers a held request after mem_wait idle cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clock);
            if (mem_read_enable === 1'b1 && reset === 1'b0) begin
                if (wcnt >= mem_wait) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem.exists(mem_addr) ? mem[mem_addr] : '1;
                    if (reads == 0) first_addr = mem_addr;
                    reads++;
                    wcnt = 0;
                end else begin
                    mem_read_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_read_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Backpressure: hold path_ready low for 5 cycles while beat 2 is offered.
    initial begin
        path_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (bp_en && path_valid === 1'b1 && path_node == 8'd2 && bp_cnt < 5) begin
                path_ready = 1'b0;
                bp_cnt++;
            end else begin
                path_ready = 1'b1;
            end
        end
    end

    // Monitor: every offered beat must match the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && path_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got node %0d expected no beat", path_node);
                end else begin
                    chk("beat_node", 64'(path_node), 64'(exp_q[0].node));
                    chk("beat_last", 64'(path_last), 64'(exp_q[0].last));
                    if (path_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_case(input string nm, input logic [IW-1:0] s, input logic [IW-1:0] d,
                            input logic [IW-1:0] n, input logic [AW-1:0] b,
                            input logic exp_err, input int exp_len, input int exp_reads,
                            input logic [AW-1:0] exp_addr);
        bit done;
        done  = 1'b0;
        reads = 0;
        @(posedge clock);
        #1;
        source          = s;
        destination     = d;
        number_of_nodes = n;
        base_address    = b;
        enable          = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (ready === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready 0 expected 1", nm);
        end else begin
            chk({nm, "_error"}, 64'(error), 64'(exp_err));
            chk({nm, "_length"}, 64'(path_length), 64'(exp_len));
            chk({nm, "_reads"}, 64'(reads), 64'(exp_reads));
            if (exp_reads > 0) chk({nm, "_first_addr"}, 64'(first_addr), 64'(exp_addr));
            chk({nm, "_beats_left"}, 64'(exp_q.size()), 64'd0);
            chk({nm, "_bus_released"}, 64'(mem_read_enable === 1'b1), 64'd0);
            repeat (3) @(negedge clock);
            chk({nm, "_ready_held"}, 64'(ready), 64'd1);
        end
        enable = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        chk({nm, "_ready_clear"}, 64'(ready), 64'd0);
        chk({nm, "_error_clear"}, 64'(error), 64'd0);
    endtask

    task automatic load_case1();
        mem.delete();
        set_prev(7, 32'd5);
        set_prev(5, 32'd2);
        set_prev(2, 32'd0);
        push_beat(8'd0, 1'b0);
        push_beat(8'd2, 1'b0);
        push_beat(8'd5, 1'b0);
        push_beat(8'd7, 1'b1);
    endtask

    initial begin
        bit saw;
        reset = 1'b1;
        enable = 1'b0;
        source = '0;
        destination = '0;
        number_of_nodes = '0;
        base_address = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_valid", 64'(path_valid), 64'd0);
        chk("rst_length", 64'(path_length), 64'd0);
        chk("rst_bus", 64'(mem_read_enable === 1'b1), 64'd0);

        load_case1();
        run_case("c1_path", 8'd0, 8'd7, 8'd8, BASE, 1'b0, 4, 3, 32'd16777460);

        mem.delete();
        set_prev(7, 32'h0000_00FF);
        run_case("c2_noprev", 8'd0, 8'd7, 8'd8, BASE, 1'b1, 0, 1, 32'd16777460);

        mem.delete();
        set_prev(7, 32'd6);
        set_prev(6, 32'd7);
        run_case("c3_cycle", 8'd0, 8'd7, 8'd8, BASE, 1'b1, 0, 7, 32'd16777460);

        mem.delete();
        push_beat(8'd3, 1'b1);
        run_case("c4_same", 8'd3, 8'd3, 8'd8, BASE, 1'b0, 1, 0, '0);

        load_case1();
        bp_en  = 1'b1;
        bp_cnt = 0;
        run_case("c5_backpressure", 8'd0, 8'd7, 8'd8, BASE, 1'b0, 4, 3, 32'd16777460);
        chk("c5_stall_cycles", 64'(bp_cnt), 64'd5);
        bp_en = 1'b0;

        mem.delete();
        run_case("bad_index", 8'd9, 8'd7, 8'd8, BASE, 1'b1, 0, 0, '0);

        // base + (64+1)*4 wraps past 2^32 to 0xF4
        mem.delete();
        mem[32'h0000_00F4] = 32'd0;
        push_beat(8'd0, 1'b0);
        push_beat(8'd1, 1'b1);
        run_case("wrap", 8'd0, 8'd1, 8'd8, 32'hFFFF_FFF0, 1'b0, 2, 1, 32'h0000_00F4);

        // Reset while a stretched read is outstanding
        mem.delete();
        set_prev(7, 32'd5);
        mem_wait = 10;
        saw = 1'b0;
        @(posedge clock);
        #1;
        source = 8'd0;
        destination = 8'd7;
        number_of_nodes = 8'd8;
        base_address = BASE;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (mem_read_enable === 1'b1) begin
                saw = 1'b1;
                break;
            end
        end
        chk("c6_read_started", 64'(saw), 64'd1);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        enable = 1'b0;
        @(negedge clock);
        chk("c6_bus_released", 64'(mem_read_enable === 1'b1), 64'd0);
        chk("c6_ready", 64'(ready), 64'd0);
        chk("c6_valid", 64'(path_valid), 64'd0);
        repeat (15) @(negedge clock);
        chk("c6_idle_after_late_ready", 64'(mem_read_enable === 1'b1), 64'd0);
        mem_wait = 0;
        load_case1();
        run_case("c6_rerun", 8'd0, 8'd7, 8'd8, BASE, 1'b0, 4, 3, 32'd16777460);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
